// File: rtl/tissue_loader_pkg.sv
// Shared types and constants for the tissue initialisation loader.
// Used by tissue_loader (top) and lfsr_galois (sub-module).
package tissue_pkg;

    // Loader control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } loader_state_e;

    // Occupancy LFSR: 16-bit Galois, right-shifting, taps 16,14,13,11.
    localparam logic [15:0] STATUS_LFSR_MASK         = 16'hB400;
    // A zero pattern seed would lock the LFSR, so it is replaced by this.
    localparam logic [15:0] STATUS_LFSR_DEFAULT_SEED = 16'hACE1;

    // Width of a counter able to hold 0..num_cells inclusive.
    function automatic int ones_count_width(input int num_cells);
        return (num_cells < 1) ? 1 : $clog2(num_cells + 1);
    endfunction

    // Galois tap masks for the optional per-cell seed LFSR, by field width.
    // Listed widths are maximal-length; other widths fall back to the top
    // bit only (a plain rotate), which still never reaches zero.
    function automatic logic [63:0] seed_lfsr_mask(input int width);
        case (width)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            24:      return 64'h0000_0000_00E1_0000;
            32:      return 64'h0000_0000_8020_0003;
            default: return 64'd1 << (width - 1);
        endcase
    endfunction

endpackage

// File: rtl/tissue_loader_lfsr.sv
// Parameterised right-shifting Galois LFSR.
// A load consumes the seed as the value already presented downstream, so the
// register always holds the next value to be emitted.
module lfsr_galois #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] MASK  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] v);
        return v[0] ? ((v >> 1) ^ MASK) : (v >> 1);
    endfunction

    // Next value: load takes priority over a plain step.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = galois_step(seed);
        end else if (enable) begin
            state_d = galois_step(state_q);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/tissue_loader.sv
// Tissue loader: streams per-cell init data into the tissue chain, then
// releases the tissue to run and reports completion.
// Optional build macro LOADER_SEED_HASH_EN: per-cell seed from a second
// Galois LFSR instead of base_seed + index.
module tissue_loader
    import tissue_pkg::*;
#(
    parameter int TISSUE_WIDTH   = 90,
    parameter int TISSUE_HEIGHT  = 3,
    parameter int NUM_STATUS     = 8,
    parameter int RANDOMIZED_LEN = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic [15:0]                            density,
    input  logic [15:0]                            pattern_seed,
    input  logic [RANDOMIZED_LEN*8-1:0]            chance_cfg,
    input  logic [2**(NUM_STATUS+1)-1:0]           rule_cfg,
    input  logic [RANDOMIZED_LEN*8-1:0]            base_seed,
    input  logic [32:0]                            steps_cfg,
    input  logic                                   tissue_done,
    output logic                                   tissue_init,
    output logic                                   cell_init_status_out,
    output logic [RANDOMIZED_LEN*8-1:0]            flip_chance_out,
    output logic [2**(NUM_STATUS+1)-1:0]           cell_logic_inputs_out,
    output logic [RANDOMIZED_LEN*8-1:0]            cell_lfsr_seed_out,
    output logic [32:0]                            number_of_steps_out,
    output logic                                   busy,
    output logic                                   run_done,
    output logic [ones_count_width(TISSUE_WIDTH*TISSUE_HEIGHT)-1:0] ones_count
);

    localparam int NUM_CELLS = TISSUE_WIDTH * TISSUE_HEIGHT;
    localparam int SEED_W    = RANDOMIZED_LEN * 8;
    localparam int RULE_W    = 2**(NUM_STATUS + 1);
    localparam int CNT_W     = ones_count_width(NUM_CELLS);
    localparam int IDX_W     = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

    loader_state_e      state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;          // emission currently presented
    logic [15:0]        density_q, density_d;
    logic               tissue_init_q, tissue_init_d;
    logic               status_q, status_d;
    logic [SEED_W-1:0]  chance_q, chance_d;
    logic [RULE_W-1:0]  rule_q, rule_d;
    logic [SEED_W-1:0]  seed_q, seed_d;
    logic [32:0]        steps_q, steps_d;
    logic               busy_q, busy_d;
    logic               run_done_q, run_done_d;
    logic [CNT_W-1:0]   ones_q, ones_d;

    logic               in_idle;
    logic               do_start;
    logic               do_advance;
    logic [15:0]        eff_pattern_seed;
    logic [15:0]        status_lfsr;
    logic [15:0]        emit_lfsr;
    logic               emit_status;
    logic [SEED_W-1:0]  emit_seed;

    assign in_idle          = (state_q == ST_IDLE);
    assign do_start         = in_idle && start && !abort;
    assign do_advance       = (state_q == ST_LOAD) && !abort && (idx_q != LAST_IDX);
    assign eff_pattern_seed = (pattern_seed == 16'd0) ? STATUS_LFSR_DEFAULT_SEED : pattern_seed;

    lfsr_galois #(
        .WIDTH (16),
        .MASK  (STATUS_LFSR_MASK)
    ) u_status_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (do_start),
        .enable (do_advance),
        .seed   (eff_pattern_seed),
        .state  (status_lfsr)
    );

`ifdef LOADER_SEED_HASH_EN
    logic [SEED_W-1:0] eff_base_seed;
    logic [SEED_W-1:0] seed_lfsr;

    assign eff_base_seed = (base_seed == '0) ? SEED_W'(1) : base_seed;

    lfsr_galois #(
        .WIDTH (SEED_W),
        .MASK  (SEED_W'(seed_lfsr_mask(SEED_W)))
    ) u_seed_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (do_start),
        .enable (do_advance),
        .seed   (eff_base_seed),
        .state  (seed_lfsr)
    );

    // Per-cell seed: hashed sequence starting at the (non-zero) base seed.
    always_comb begin
        emit_seed = in_idle ? eff_base_seed : seed_lfsr;
    end
`else
    logic [SEED_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  emit_idx;
    logic [SEED_W-1:0] seed_sum;

    // Per-cell seed: base + index, with zero replaced by 1.
    always_comb begin
        emit_idx  = in_idle ? '0 : idx_q + IDX_W'(1);
        seed_sum  = (in_idle ? base_seed : base_q) + SEED_W'(emit_idx);
        emit_seed = (seed_sum == '0) ? SEED_W'(1) : seed_sum;
    end
`endif

    // Occupancy of the emission about to be registered. At the start edge
    // the config inputs are used directly since nothing is latched yet.
    always_comb begin
        emit_lfsr   = in_idle ? eff_pattern_seed : status_lfsr;
        emit_status = (emit_lfsr <= (in_idle ? density : density_q));
    end

    // Control FSM next state and registered-output values.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        density_d     = density_q;
        tissue_init_d = tissue_init_q;
        status_d      = status_q;
        chance_d      = chance_q;
        rule_d        = rule_q;
        seed_d        = seed_q;
        steps_d       = steps_q;
        ones_d        = ones_q;
        run_done_d    = 1'b0;
`ifndef LOADER_SEED_HASH_EN
        base_d        = base_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_LOAD;
                    idx_d         = '0;
                    density_d     = density;
`ifndef LOADER_SEED_HASH_EN
                    base_d        = base_seed;
`endif
                    tissue_init_d = 1'b1;
                    status_d      = emit_status;
                    chance_d      = chance_cfg;
                    rule_d        = rule_cfg;
                    seed_d        = emit_seed;
                    steps_d       = steps_cfg;
                    ones_d        = CNT_W'(emit_status);
                end
            end
            ST_LOAD: begin
                if (idx_q == LAST_IDX) begin
                    state_d       = ST_RUN;
                    tissue_init_d = 1'b0;
                    status_d      = 1'b0;
                    chance_d      = '0;
                    rule_d        = '0;
                    seed_d        = '0;
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    status_d = emit_status;
                    seed_d   = emit_seed;
                    ones_d   = ones_q + CNT_W'(emit_status);
                end
            end
            ST_RUN: begin
                if (tissue_done) begin
                    state_d    = ST_FINISH;
                    run_done_d = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort drops everything back to idle; the chain may be half loaded.
        if (abort) begin
            state_d       = ST_IDLE;
            tissue_init_d = 1'b0;
            run_done_d    = 1'b0;
            status_d      = 1'b0;
            chance_d      = '0;
            rule_d        = '0;
            seed_d        = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            density_q     <= '0;
            tissue_init_q <= 1'b0;
            status_q      <= 1'b0;
            chance_q      <= '0;
            rule_q        <= '0;
            seed_q        <= '0;
            steps_q       <= '0;
            busy_q        <= 1'b0;
            run_done_q    <= 1'b0;
            ones_q        <= '0;
`ifndef LOADER_SEED_HASH_EN
            base_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            density_q     <= density_d;
            tissue_init_q <= tissue_init_d;
            status_q      <= status_d;
            chance_q      <= chance_d;
            rule_q        <= rule_d;
            seed_q        <= seed_d;
            steps_q       <= steps_d;
            busy_q        <= busy_d;
            run_done_q    <= run_done_d;
            ones_q        <= ones_d;
`ifndef LOADER_SEED_HASH_EN
            base_q        <= base_d;
`endif
        end
    end

    assign tissue_init           = tissue_init_q;
    assign cell_init_status_out  = status_q;
    assign flip_chance_out       = chance_q;
    assign cell_logic_inputs_out = rule_q;
    assign cell_lfsr_seed_out    = seed_q;
    assign number_of_steps_out   = steps_q;
    assign busy                  = busy_q;
    assign run_done              = run_done_q;
    assign ones_count            = ones_q;

endmodule

// File: tb/tb_tissue_loader.sv
// Directed testbench for tissue_loader on a 4x2 tissue with a scoreboard of
// expected emissions.
module tb_tissue_loader;

    localparam int TW = 4;
    localparam int TH = 2;
    localparam int NS = 3;
    localparam int RL = 2;
    localparam int N  = TW * TH;
    localparam int SW = RL * 8;
    localparam int RW = 2**(NS + 1);
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [15:0]   density;
    logic [15:0]   pattern_seed;
    logic [SW-1:0] chance_cfg;
    logic [RW-1:0] rule_cfg;
    logic [SW-1:0] base_seed;
    logic [32:0]   steps_cfg;
    logic          tissue_done;
    logic          tissue_init;
    logic          cell_init_status_out;
    logic [SW-1:0] flip_chance_out;
    logic [RW-1:0] cell_logic_inputs_out;
    logic [SW-1:0] cell_lfsr_seed_out;
    logic [32:0]   number_of_steps_out;
    logic          busy;
    logic          run_done;
    logic [CW-1:0] ones_count;

    tissue_loader #(
        .TISSUE_WIDTH   (TW),
        .TISSUE_HEIGHT  (TH),
        .NUM_STATUS     (NS),
        .RANDOMIZED_LEN (RL)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .abort                 (abort),
        .density               (density),
        .pattern_seed          (pattern_seed),
        .chance_cfg            (chance_cfg),
        .rule_cfg              (rule_cfg),
        .base_seed             (base_seed),
        .steps_cfg             (steps_cfg),
        .tissue_done           (tissue_done),
        .tissue_init           (tissue_init),
        .cell_init_status_out  (cell_init_status_out),
        .flip_chance_out       (flip_chance_out),
        .cell_logic_inputs_out (cell_logic_inputs_out),
        .cell_lfsr_seed_out    (cell_lfsr_seed_out),
        .number_of_steps_out   (number_of_steps_out),
        .busy                  (busy),
        .run_done              (run_done),
        .ones_count            (ones_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          status;
        logic [SW-1:0] seed;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [SW-1:0] chain_seed [N];
    logic [N-1:0]  status_stream;
    logic [N-1:0]  saved_stream;
    logic [SW-1:0] exp_chance;
    logic [RW-1:0] exp_rule;
    logic [32:0]   exp_steps;
    int            exp_ones;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        logic [15:0] r;
        r = {1'b0, v[15:1]};
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Drive a start and push the whole expected emission sequence.
    task automatic do_start(input logic [15:0] dens, input logic [15:0] pseed,
                            input logic [SW-1:0] base, input logic [SW-1:0] chance,
                            input logic [RW-1:0] rule, input logic [32:0] steps);
        logic [15:0]   lf;
        logic [SW-1:0] hs;
        logic [SW-1:0] sum;
        exp_t          e;
        @(negedge clk);
        density      = dens;
        pattern_seed = pseed;
        base_seed    = base;
        chance_cfg   = chance;
        rule_cfg     = rule;
        steps_cfg    = steps;
        start        = 1'b1;
        exp_chance   = chance;
        exp_rule     = rule;
        exp_steps    = steps;
        exp_ones     = 0;
        sb.delete();
        lf = (pseed == 16'd0) ? 16'hACE1 : pseed;
        hs = (base == '0) ? SW'(1) : base;
        for (int i = 0; i < N; i++) begin
            e.status = (lf <= dens);
`ifdef LOADER_SEED_HASH_EN
            e.seed = hs;
`else
            sum    = base + SW'(i);
            e.seed = (sum == '0) ? SW'(1) : sum;
`endif
            if (e.status) exp_ones++;
            sb.push_back(e);
            lf = ref_step(lf);
            hs = SW'(ref_step(16'(hs)));
        end
        $display("start: density=%04h pseed=%04h base=%04h", dens, pseed, base);
    endtask

    // Follow a load, popping and comparing each emission; optionally abort
    // on the given load cycle (1-based, 0 = never).
    task automatic drain_load(input int abort_at);
        int   seen;
        bit   done;
        exp_t e;
        seen          = 0;
        done          = 1'b0;
        status_stream = '0;
        for (int c = 0; c < N + 6 && !done; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (tissue_init === 1'b1) begin
                check("sb_avail", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("status", 64'(cell_init_status_out), 64'(e.status));
                    check("seed", 64'(cell_lfsr_seed_out), 64'(e.seed));
                    check("chance", 64'(flip_chance_out), 64'(exp_chance));
                    check("rule", 64'(cell_logic_inputs_out), 64'(exp_rule));
                    check("steps", 64'(number_of_steps_out), 64'(exp_steps));
                    check("load_busy", 64'(busy), 64'd1);
                    $display("emit %0d: status=%0b seed=%04h", seen,
                             cell_init_status_out, cell_lfsr_seed_out);
                end
                for (int k = N - 1; k > 0; k--) chain_seed[k] = chain_seed[k-1];
                chain_seed[0] = cell_lfsr_seed_out;
                if (seen < N) status_stream[seen] = cell_init_status_out;
                seen++;
                if (seen == abort_at) abort = 1'b1;
            end else if (seen > 0) begin
                done = 1'b1;
            end
        end
        if (abort_at > 0) begin
            check("abort_cycles", 64'(seen), 64'(abort_at));
            check("abort_busy", 64'(busy), 64'd0);
            check("abort_run_done", 64'(run_done), 64'd0);
            check("abort_seed_zero", 64'(cell_lfsr_seed_out), 64'd0);
            check("abort_steps_held", 64'(number_of_steps_out), 64'(exp_steps));
            sb.delete();
        end else begin
            check("init_cycles", 64'(seen), 64'(N));
            check("ones_count", 64'(ones_count), 64'(exp_ones));
            check("run_busy_entry", 64'(busy), 64'd1);
            check("run_chain_zero", 64'(cell_lfsr_seed_out), 64'd0);
            check("sb_empty", 64'(sb.size()), 64'd0);
        end
    endtask

    // Tissue model: done 10 cycles after init falls; optional start poke.
    task automatic run_phase(input bit poke_start);
        int pulses;
        pulses = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            start = (poke_start && c == 4);
            if (c == 5 || c == 8) begin
                check("run_busy", 64'(busy), 64'd1);
                check("run_no_init", 64'(tissue_init), 64'd0);
                check("run_no_done", 64'(run_done), 64'd0);
            end
        end
        @(negedge clk);
        start       = 1'b0;
        tissue_done = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tissue_done = 1'b0;
            if (run_done === 1'b1) pulses++;
        end
        check("run_done_pulses", 64'(pulses), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_init", 64'(tissue_init), 64'd0);
        check("idle_steps_held", 64'(number_of_steps_out), 64'(exp_steps));
        $display("run complete: pulses=%0d", pulses);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        tissue_done  = 1'b0;
        density      = '0;
        pattern_seed = '0;
        chance_cfg   = '0;
        rule_cfg     = '0;
        base_seed    = '0;
        steps_cfg    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_init", 64'(tissue_init), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_run_done", 64'(run_done), 64'd0);
        check("rst_ones", 64'(ones_count), 64'd0);
        check("rst_seed", 64'(cell_lfsr_seed_out), 64'd0);
        check("rst_steps", 64'(number_of_steps_out), 64'd0);
        $display("reset checked");

        // density 0: all cells empty; start during RUN is ignored
        do_start(16'h0000, 16'hACE1, 16'd5, 16'h1234, 16'hBEEF, 33'h1_0000_0007);
        drain_load(0);
        check("dens0_ones", 64'(ones_count), 64'd0);
        run_phase(1'b1);

        // density max: all cells occupied, seeds 5..12
        do_start(16'hFFFF, 16'h1357, 16'd5, 16'h00A5, 16'h0F0F, 33'd100);
        drain_load(0);
        check("densmax_ones", 64'(ones_count), 64'd8);
        check("cell0_seed", 64'(chain_seed[0]), 64'd12);
        run_phase(1'b0);

        // pattern_seed 0 behaves as 16'hACE1
        do_start(16'h8000, 16'h0000, 16'd9, 16'h0001, 16'h1111, 33'd3);
        drain_load(0);
        saved_stream = status_stream;
        run_phase(1'b0);
        do_start(16'h8000, 16'hACE1, 16'd9, 16'h0001, 16'h1111, 33'd3);
        drain_load(0);
        check("seed0_stream", 64'(status_stream), 64'(saved_stream));
        run_phase(1'b0);
        // first emitted LFSR value is ACE1: threshold just below/at it
        do_start(16'hACE0, 16'h0000, 16'd1, 16'h0001, 16'h1111, 33'd3);
        drain_load(0);
        check("first_below", 64'(status_stream[0]), 64'd0);
        run_phase(1'b0);
        do_start(16'hACE1, 16'h0000, 16'd1, 16'h0001, 16'h1111, 33'd3);
        drain_load(0);
        check("first_at", 64'(status_stream[0]), 64'd1);
        run_phase(1'b0);

        // abort on load cycle 3, then a clean reload from emission 0
        do_start(16'h9000, 16'h2468, 16'd40, 16'h7777, 16'h5A5A, 33'd55);
        drain_load(3);
        do_start(16'h9000, 16'h2468, 16'd40, 16'h7777, 16'h5A5A, 33'd56);
        drain_load(0);
        run_phase(1'b0);

        // seed wrap at the field boundary
        do_start(16'h6000, 16'hBEEF, 16'hFFFF, 16'h0002, 16'h8001, 33'd9);
        drain_load(0);
        run_phase(1'b0);

        // reset mid-load returns to idle with chain outputs cleared
        do_start(16'h7000, 16'h4321, 16'd3, 16'h0003, 16'h00FF, 33'd11);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_init", 64'(tissue_init), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_seed", 64'(cell_lfsr_seed_out), 64'd0);
        check("midrst_ones", 64'(ones_count), 64'd0);
        sb.delete();
        $display("mid-load reset checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tissue_loader.md
Name: tissue_loader

Overview:
- Drives the serial initialisation chain of the cellular-automata tissue from compact host configuration.
- Generates each cell's initial occupancy from a density-controlled LFSR, plus per-cell chance, rule table and LFSR seed.
- Shifts these into the chain over exactly NUM_CELLS init cycles, then releases the tissue to run and reports completion.
- Sits between the host/testbench controller and the tissue; the generated stream replaces hand-written init vectors.

Parameters:
- TISSUE_WIDTH, 90, cells per row
- TISSUE_HEIGHT, 3, rows
- NUM_STATUS, 8, neighbour status bits per cell (sets rule-table width)
- RANDOMIZED_LEN, 2, bytes of chance/seed (field width RANDOMIZED_LEN*8)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin load+run; honoured only in IDLE
- abort  in  1  return to IDLE from any state
- density  in  16  occupancy threshold
- pattern_seed  in  16  status-LFSR seed; 0 means 16'hACE1
- chance_cfg  in  RANDOMIZED_LEN*8  flip chance, same for all cells
- rule_cfg  in  2**(NUM_STATUS+1)  cell truth table, same for all cells
- base_seed  in  RANDOMIZED_LEN*8  per-cell seed base
- steps_cfg  in  33  simulation steps
- tissue_done  in  1  done from tissue
- tissue_init  out  1  init to tissue
- cell_init_status_out  out  1  chain status bit
- flip_chance_out  out  RANDOMIZED_LEN*8  chain chance
- cell_logic_inputs_out  out  2**(NUM_STATUS+1)  chain rule table
- cell_lfsr_seed_out  out  RANDOMIZED_LEN*8  chain seed
- number_of_steps_out  out  33  latched steps_cfg
- busy  out  1  state != IDLE
- run_done  out  1  one-cycle completion pulse
- ones_count  out  clog2(NUM_CELLS+1)  occupied cells emitted in the last load

Behaviour:
- NUM_CELLS = TISSUE_WIDTH*TISSUE_HEIGHT. All outputs are registered.
- Reset values: every output is 0, state is IDLE, and the counters are 0.
- FSM states: IDLE, LOAD, RUN, FINISH.
- IDLE -> LOAD: on start. Latch all cfg inputs. Status LFSR <= pattern_seed, or 16'hACE1 if that is zero. Emission index i <= 0. Clear ones_count.
- LOAD:
  - tissue_init=1 on exactly NUM_CELLS consecutive cycles, with no gaps. The first LOAD cycle follows the start edge.
  - Each cycle presents emission i. i=0 lands in cell NUM_CELLS-1; cell k holds emission NUM_CELLS-1-k.
  - status = (lfsr <= density). density=0 gives all 0; 16'hFFFF gives all 1.
  - LFSR: 16-bit Galois, mask 16'hB400, advanced once per emission.
  - seed = base_seed + i, truncated to field width; a zero result is replaced by 1.
  - ones_count increments per emitted 1.
- LOAD -> RUN: after emission NUM_CELLS-1. tissue_init=0 from that edge.
- RUN -> FINISH: on tissue_done=1. A tissue_done seen in IDLE or LOAD is ignored.
- FINISH: run_done=1 for one cycle, then IDLE.
- start while busy: ignored.
- abort: highest priority after rst. Next state is IDLE, tissue_init=0, no run_done.
  - The tissue may be partially loaded; this is the caller's responsibility.
- rst mid-operation: returns to IDLE next edge. Chain data outputs are held at 0 except during LOAD.
- number_of_steps_out: stable from LOAD entry until the next start.

Optional Feature:
- Macro LOADER_SEED_HASH_EN.
- Defined: the per-cell seed comes from a second Galois LFSR of width RANDOMIZED_LEN*8, initialised to base_seed (0 maps to 1) and stepped once per emission.
  - Mask: 16'hB400 for width 16; otherwise a localparam table in the package.
- Undefined: seed = base_seed + i as above.
- Status generation and timing are identical in both builds.

Decomposition:
- Package tissue_pkg holds:
  - state enum
  - LFSR masks and default seed 16'hACE1
  - localparam function computing the ones_count width
- Natural sub-module: lfsr_galois (parameterised width/mask, load, enable). Instantiated once for status, and once more under LOADER_SEED_HASH_EN.

Test Plan:
- 4x2 tissue, density=0, start -> tissue_init high exactly 8 cycles; all status bits 0; ones_count=0; busy=1 throughout.
- density=16'hFFFF, base_seed=5 -> all status 1, ones_count=8; seeds 5,6,…,12 in emission order; the cell-0 shift register ends with seed 12.
- pattern_seed=0 vs 16'hACE1 -> identical status streams; the first emitted LFSR value is 16'hACE1.
- Tissue model asserting tissue_done 10 cycles after init falls -> run_done pulses once, then IDLE; start during RUN has no effect.
- abort on load cycle 3 -> tissue_init low next cycle, busy=0, no run_done; a new start reloads from i=0.
- base_seed=16'hFFFF, 8 cells -> second emission wraps to 0 and is replaced by 1 (macro off); with LOADER_SEED_HASH_EN, seeds match the reference LFSR sequence from 16'hFFFF.
